ad80305_rx_dc_track: RTL and testbench

Parametrised RX DC-offset estimator and corrector in the 125 MHz FPGA domain, placed after the AD80305 RX DDR LVCMOS interface and fed by its fp/I/Q outputs. It block-averages 2^AVG_LOG2 I/Q samples and reports the average. It subtracts either the tracked average or a manual offset, with saturation. It adds an auto-tracking lock state, runtime restart and parametrised widths.

---
 rtl/ad80305_rx_dc_track.sv | 148 ++++++++++++++
 tb/tb_ad80305_rx_dc_track.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ad80305_rx_dc_track.sv
// RX DC-offset tracker for the AD80305 I/Q stream (125 MHz domain).
// Block-averages I/Q, subtracts tracked or manual offset with saturation.
module ad80305_rx_dc_track #(
    parameter int DATA_W   = 12,
    parameter int CORR_W   = 8,
    parameter int AVG_LOG2 = 4
) (
    input  logic                     i_fpga_clk_125p,
    input  logic                     i_fpga_rst_125p,
    input  logic                     i_iqdata_fp,
    input  logic signed [DATA_W-1:0] i_idata,
    input  logic signed [DATA_W-1:0] i_qdata,
    input  logic                     i_dc_bypass,
    input  logic                     i_dc_set_sw,
    input  logic signed [CORR_W-1:0] i_dc_corr_idata,
    input  logic signed [CORR_W-1:0] i_dc_corr_qdata,
    input  logic                     i_avg_clr,
    output logic                     o_iqdata_fp,
    output logic signed [DATA_W-1:0] o_idata,
    output logic signed [DATA_W-1:0] o_qdata,
    output logic signed [DATA_W-1:0] o_aver_idata,
    output logic signed [DATA_W-1:0] o_aver_qdata,
    output logic                     o_aver_valid,
    output logic                     o_dc_locked,
    output logic                     o_sat
);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0]  acc_i, acc_q, sum_i, sum_q;
    logic        [AVG_LOG2-1:0] cnt;
    logic signed [DATA_W-1:0] off_i, off_q, avg_i, avg_q;
    logic signed [DATA_W-1:0] man_i, man_q, cor_i, cor_q;
    logic signed [DATA_W:0]   dif_i, dif_q;
    logic                     take, done, clip_i, clip_q;

    assign take  = i_iqdata_fp && !i_avg_clr;
    assign done  = take && (cnt == {AVG_LOG2{1'b1}});
    assign sum_i = acc_i + {{AVG_LOG2{i_idata[DATA_W-1]}}, i_idata};
    assign sum_q = acc_q + {{AVG_LOG2{i_qdata[DATA_W-1]}}, i_qdata};
    // Dropping the low bits of the sum is an arithmetic shift (floor).
    assign avg_i = sum_i[ACC_W-1:AVG_LOG2];
    assign avg_q = sum_q[ACC_W-1:AVG_LOG2];

    assign man_i = {{(DATA_W-CORR_W){i_dc_corr_idata[CORR_W-1]}}, i_dc_corr_idata};
    assign man_q = {{(DATA_W-CORR_W){i_dc_corr_qdata[CORR_W-1]}}, i_dc_corr_qdata};

    assign dif_i  = {i_idata[DATA_W-1], i_idata} - {off_i[DATA_W-1], off_i};
    assign dif_q  = {i_qdata[DATA_W-1], i_qdata} - {off_q[DATA_W-1], off_q};
    assign clip_i = dif_i[DATA_W] ^ dif_i[DATA_W-1];
    assign clip_q = dif_q[DATA_W] ^ dif_q[DATA_W-1];
    assign cor_i  = clip_i ? (dif_i[DATA_W] ? SMIN : SMAX) : dif_i[DATA_W-1:0];
    assign cor_q  = clip_q ? (dif_q[DATA_W] ? SMIN : SMAX) : dif_q[DATA_W-1:0];

    assign o_dc_locked = (state == LOCKED);

    // Lock state register.
    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) state <= UNLOCKED;
        else                  state <= state_nxt;
    end

    // Next lock state: clear beats block completion.
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            i_avg_clr: state_nxt = UNLOCKED;
            done:      state_nxt = LOCKED;
            default:   state_nxt = state;
        endcase
    end

    // Block accumulation and average reporting.
    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            acc_i        <= '0;
            acc_q        <= '0;
            cnt          <= '0;
            o_aver_idata <= '0;
            o_aver_qdata <= '0;
            o_aver_valid <= 1'b0;
        end else begin
            o_aver_valid <= 1'b0;
            if (i_avg_clr) begin
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else if (done) begin
                acc_i        <= '0;
                acc_q        <= '0;
                cnt          <= '0;
                o_aver_idata <= avg_i;
                o_aver_qdata <= avg_q;
                o_aver_valid <= 1'b1;
            end else if (take) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    // Offset registers: manual every cycle, else refreshed per completed block.
    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            off_i <= '0;
            off_q <= '0;
        end else if (i_dc_set_sw) begin
            off_i <= man_i;
            off_q <= man_q;
        end else if (done) begin
            off_i <= avg_i;
            off_q <= avg_q;
        end
    end

    // Registered correction; outputs hold between strobes.
    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            o_iqdata_fp <= 1'b0;
            o_idata     <= '0;
            o_qdata     <= '0;
            o_sat       <= 1'b0;
        end else begin
            o_iqdata_fp <= i_iqdata_fp;
            o_sat       <= 1'b0;
            if (i_iqdata_fp) begin
                if (i_dc_bypass) begin
                    o_idata <= i_idata;
                    o_qdata <= i_qdata;
                end else begin
                    o_idata <= cor_i;
                    o_qdata <= cor_q;
                    o_sat   <= clip_i | clip_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ad80305_rx_dc_track.sv
// Randomised and directed bench for ad80305_rx_dc_track.
// Reference model works on plain integers and block sums.
module tb_ad80305_rx_dc_track;
    localparam int W  = 12;
    localparam int CW = 8;
    localparam int L  = 4;
    localparam int N  = 16;
    localparam int HI = 2047;
    localparam int LO = -2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fp = 1'b0, byp = 1'b0, sw = 1'b0, clr = 1'b0;
    logic signed [W-1:0]  idat = '0, qdat = '0;
    logic signed [CW-1:0] ci = '0, cq = '0;
    logic ofp, valid, locked, sat;
    logic signed [W-1:0] oi, oq, ai, aq;

    int errors = 0;
    int checks = 0;

    int m_oi, m_oq, m_ai, m_aq, m_offi, m_offq, m_sumi, m_sumq, m_n;
    bit m_fp, m_valid, m_locked, m_sat;

    ad80305_rx_dc_track #(.DATA_W(W), .CORR_W(CW), .AVG_LOG2(L)) dut (
        .i_fpga_clk_125p (clk),
        .i_fpga_rst_125p (rst_n),
        .i_iqdata_fp     (fp),
        .i_idata         (idat),
        .i_qdata         (qdat),
        .i_dc_bypass     (byp),
        .i_dc_set_sw     (sw),
        .i_dc_corr_idata (ci),
        .i_dc_corr_qdata (cq),
        .i_avg_clr       (clr),
        .o_iqdata_fp     (ofp),
        .o_idata         (oi),
        .o_qdata         (oq),
        .o_aver_idata    (ai),
        .o_aver_qdata    (aq),
        .o_aver_valid    (valid),
        .o_dc_locked     (locked),
        .o_sat           (sat)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic int clamp(input int v);
        if (v > HI) return HI;
        if (v < LO) return LO;
        return v;
    endfunction

    task automatic model_reset();
        m_oi = 0; m_oq = 0; m_ai = 0; m_aq = 0;
        m_offi = 0; m_offq = 0; m_sumi = 0; m_sumq = 0; m_n = 0;
        m_fp = 0; m_valid = 0; m_locked = 0; m_sat = 0;
    endtask

    task automatic check_all(input string t);
        chk({t, ".fp"}, int'(ofp), int'(m_fp));
        chk({t, ".i"}, int'(oi), m_oi);
        chk({t, ".q"}, int'(oq), m_oq);
        chk({t, ".avi"}, int'(ai), m_ai);
        chk({t, ".avq"}, int'(aq), m_aq);
        chk({t, ".avv"}, int'(valid), int'(m_valid));
        chk({t, ".lock"}, int'(locked), int'(m_locked));
        chk({t, ".sat"}, int'(sat), int'(m_sat));
    endtask

    // One clock: drive, predict, clock, compare.
    task automatic cycle(input string t, input bit f, input int x, input int q, input bit c);
        int di, dq;
        bit done;
        fp = f; idat = W'(x); qdat = W'(q); clr = c;
        m_valid = 0; m_sat = 0; m_fp = f; done = 0;
        if (f) begin
            if (byp) begin
                m_oi = x; m_oq = q;
            end else begin
                di = x - m_offi; dq = q - m_offq;
                m_oi = clamp(di); m_oq = clamp(dq);
                m_sat = (di != m_oi) || (dq != m_oq);
            end
        end
        if (f && !c) begin
            m_sumi += x; m_sumq += q; m_n++;
            if (m_n == N) begin
                m_ai = floor_div(m_sumi); m_aq = floor_div(m_sumq);
                m_valid = 1; m_locked = 1; done = 1;
                m_n = 0; m_sumi = 0; m_sumq = 0;
            end
        end
        if (c) begin
            m_n = 0; m_sumi = 0; m_sumq = 0; m_locked = 0;
        end
        if (sw) begin
            m_offi = int'(ci); m_offq = int'(cq);
        end else if (done) begin
            m_offi = m_ai; m_offq = m_aq;
        end
        @(posedge clk);
        #1;
        check_all(t);
        fp = 0; clr = 0;
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("rst");
        @(negedge clk) rst_n = 1'b1;

        // Reset mid-block
        for (int k = 0; k < 7; k++) cycle("pre", 1, rnd_s(), rnd_s(), 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk) rst_n = 1'b1;

        // Auto mode, constant 100/-50
        for (int k = 0; k < 16; k++) cycle("blk", 1, 100, -50, 0);
        chk("blk.avi_c", int'(ai), 100);
        chk("blk.avq_c", int'(aq), -50);
        chk("blk.lock_c", int'(locked), 1);
        cycle("blk17", 1, 100, -50, 0);
        chk("blk17.i_c", int'(oi), 0);
        chk("blk17.q_c", int'(oq), 0);

        // Floor rounding
        cycle("clr", 0, 0, 0, 1);
        for (int k = 0; k < 15; k++) cycle("flr", 1, -1, 3, 0);
        cycle("flr", 1, 0, 3, 0);
        chk("flr.avi_c", int'(ai), -1);

        // Manual saturation
        sw = 1; ci = -8'sd128; cq = 8'sd0;
        cycle("man", 0, 0, 0, 0);
        cycle("satp", 1, 2000, 0, 0);
        chk("satp.i_c", int'(oi), 2047);
        chk("satp.sat_c", int'(sat), 1);
        ci = 8'sd127;
        cycle("man", 0, 0, 0, 0);
        cycle("satn", 1, -2000, 0, 0);
        chk("satn.i_c", int'(oi), -2048);
        chk("satn.sat_c", int'(sat), 1);

        // Bypass with gaps
        sw = 0; byp = 1;
        cycle("clr", 0, 0, 0, 1);
        for (int k = 0; k < 32; k++) begin
            cycle("byp", 1, 300, -7, 0);
            chk("byp.i_c", int'(oi), 300);
            if ((k % 3) == 0) cycle("gap", 0, rnd_s(), rnd_s(), 0);
        end
        byp = 0;

        // Clear coincident with strobe 9
        for (int k = 0; k < 8; k++) cycle("c8", 1, 500, 20, 0);
        cycle("c9", 1, 500, 20, 1);
        chk("c9.lock_c", int'(locked), 0);
        for (int k = 0; k < 16; k++) cycle("c16", 1, 40 + k, -k, 0);
        chk("c16.avi_c", int'(ai), 47);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 2) sw = ~sw;
            if ($urandom_range(99) < 3) byp = ~byp;
            ci = CW'($urandom); cq = CW'($urandom);
            cycle("rnd", $urandom_range(1), rnd_s(), rnd_s(), $urandom_range(99) < 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
